// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: one outstanding transaction on the SRAM-like
// instruction bus, a one-word response buffer for decode stalls, and the IF/ID register.
module if_fetch_ctrl #(
  parameter logic [31:0] INST_NOP = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] pc,
  input  logic        pc_ce,
  input  logic [5:0]  stall,
  input  logic        flush,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        stallreq_if,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;

  logic        deliver;
  logic [31:0] deliver_word;
  logic        stallreq;

  // Only the IF/ID hold bit of the stall vector matters to this stage.
  logic unused_stall;
  assign unused_stall = ^{stall[5:2], stall[0]};

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    buf_d        = buf_q;
    deliver      = 1'b0;
    deliver_word = buf_q;
    stallreq     = 1'b1;

    case (state_q)
      S_IDLE: begin
        stallreq = pc_ce & ~flush;
        if (pc_ce && !flush) begin
          addr_d  = pc;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (flush) stallreq = 1'b0;
        if (inst_addr_ok) begin
          state_d = flush ? S_DROP : S_WAIT;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          if (flush) begin
            stallreq = 1'b0;
            state_d  = S_IDLE;
          end else if (!stall[1]) begin
            stallreq     = 1'b0;
            deliver      = 1'b1;
            deliver_word = inst_rdata;
            state_d      = S_IDLE;
          end else begin
            buf_d   = inst_rdata;
            state_d = S_HOLD;
          end
        end else if (flush) begin
          stallreq = 1'b0;
          state_d  = S_DROP;
        end
      end
      S_HOLD: begin
        if (flush) begin
          stallreq = 1'b0;
          state_d  = S_IDLE;
        end else if (!stall[1]) begin
          stallreq = 1'b0;
          deliver  = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_DROP: begin
        // A flush here is already being honoured: the response is discarded anyway.
        if (inst_data_ok) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    if (flush) begin
      id_inst_d  = INST_NOP;
      id_valid_d = 1'b0;
    end else if (stall[1]) begin
      id_valid_d = id_valid_q;
    end else if (deliver) begin
      id_pc_d    = addr_q;
      id_inst_d  = deliver_word;
      id_valid_d = 1'b1;
    end else begin
      id_inst_d  = INST_NOP;
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      addr_q     <= 32'h0;
      buf_q      <= 32'h0;
      id_pc_q    <= 32'h0;
      id_inst_q  <= INST_NOP;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      buf_q      <= buf_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign inst_req    = (state_q == S_REQ);
  assign inst_addr   = addr_q;
  assign stallreq_if = stallreq;
  assign id_pc       = id_pc_q;
  assign id_inst     = id_inst_q;
  assign id_valid    = id_valid_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios followed by a
// randomized run against a transaction-level reference model.
module tb_if_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rstn;
  logic [31:0] pc;
  logic        pc_ce;
  logic [5:0]  stall;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        stallreq_if;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;

  int tests_run;
  int tests_failed;

  if_fetch_ctrl #(.INST_NOP(NOP)) dut (
    .clk(clk), .rstn(rstn), .pc(pc), .pc_ce(pc_ce), .stall(stall), .flush(flush),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .stallreq_if(stallreq_if),
    .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_bus();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    flush        = 1'b0;
    stall        = 6'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; pc = 32'h0; pc_ce = 1'b0; inst_rdata = 32'h0;
    clear_bus();
    sample();
    tests_run++; if (inst_req !== 1'b0) begin tests_failed++; $display("FAIL rst_req got %b want 0", inst_req); end
    tests_run++; if (inst_addr !== 32'h0) begin tests_failed++; $display("FAIL rst_addr got %h want 0", inst_addr); end
    tests_run++; if (id_pc !== 32'h0) begin tests_failed++; $display("FAIL rst_id_pc got %h want 0", id_pc); end
    tests_run++; if (id_inst !== NOP) begin tests_failed++; $display("FAIL rst_id_inst got %h want %h", id_inst, NOP); end
    tests_run++; if (id_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_id_valid got %b want 0", id_valid); end
    tests_run++; if (stallreq_if !== 1'b0) begin tests_failed++; $display("FAIL rst_stallreq got %b want 0", stallreq_if); end
    drive();
    rstn = 1'b1;
  endtask

  task automatic test_zero_wait();
    drive(); clear_bus(); pc_ce = 1'b1; pc = 32'hBFC0_0000;
    sample();
    tests_run++; if (stallreq_if !== 1'b1) begin tests_failed++; $display("FAIL zw_c0_stallreq got %b want 1", stallreq_if); end
    tests_run++; if (inst_req !== 1'b0) begin tests_failed++; $display("FAIL zw_c0_req got %b want 0", inst_req); end
    drive(); clear_bus(); inst_addr_ok = 1'b1;
    sample();
    tests_run++; if (inst_req !== 1'b1) begin tests_failed++; $display("FAIL zw_c1_req got %b want 1", inst_req); end
    tests_run++; if (inst_addr !== 32'hBFC0_0000) begin tests_failed++; $display("FAIL zw_c1_addr got %h want bfc00000", inst_addr); end
    tests_run++; if (stallreq_if !== 1'b1) begin tests_failed++; $display("FAIL zw_c1_stallreq got %b want 1", stallreq_if); end
    drive(); clear_bus(); inst_data_ok = 1'b1; inst_rdata = 32'h2408_0001;
    sample();
    tests_run++; if (stallreq_if !== 1'b0) begin tests_failed++; $display("FAIL zw_c2_stallreq got %b want 0", stallreq_if); end
    drive(); clear_bus(); pc_ce = 1'b0;
    sample();
    tests_run++; if (id_pc !== 32'hBFC0_0000) begin tests_failed++; $display("FAIL zw_id_pc got %h want bfc00000", id_pc); end
    tests_run++; if (id_inst !== 32'h2408_0001) begin tests_failed++; $display("FAIL zw_id_inst got %h want 24080001", id_inst); end
    tests_run++; if (id_valid !== 1'b1) begin tests_failed++; $display("FAIL zw_id_valid got %b want 1", id_valid); end
    $display("[TB] zero_wait: pc=%h inst=%h valid=%b", id_pc, id_inst, id_valid);
    drive();
    sample();
    tests_run++; if (id_valid !== 1'b0) begin tests_failed++; $display("FAIL zw_bubble_valid got %b want 0", id_valid); end
  endtask

  task automatic test_addr_delay();
    drive(); clear_bus(); pc_ce = 1'b1; pc = 32'hBFC0_0004;
    sample();
    for (int i = 0; i < 4; i++) begin
      drive(); clear_bus(); pc = 32'h1234_5678; inst_addr_ok = (i == 3);
      sample();
      tests_run++; if (inst_req !== 1'b1) begin tests_failed++; $display("FAIL dly_req c%0d got %b want 1", i, inst_req); end
      tests_run++; if (inst_addr !== 32'hBFC0_0004) begin tests_failed++; $display("FAIL dly_addr c%0d got %h want bfc00004", i, inst_addr); end
      tests_run++; if (stallreq_if !== 1'b1) begin tests_failed++; $display("FAIL dly_stallreq c%0d got %b want 1", i, stallreq_if); end
    end
    drive(); clear_bus(); inst_data_ok = 1'b1; inst_rdata = 32'h1111_2222;
    sample();
    tests_run++; if (stallreq_if !== 1'b0) begin tests_failed++; $display("FAIL dly_dlv_stallreq got %b want 0", stallreq_if); end
    drive(); clear_bus(); pc_ce = 1'b0;
    sample();
    tests_run++; if ({id_valid, id_pc, id_inst} !== {1'b1, 32'hBFC0_0004, 32'h1111_2222}) begin
      tests_failed++; $display("FAIL dly_deliver got %b/%h/%h want 1/bfc00004/11112222", id_valid, id_pc, id_inst); end
    $display("[TB] addr_delay: pc=%h inst=%h valid=%b", id_pc, id_inst, id_valid);
    drive();
    sample();
    tests_run++; if (id_valid !== 1'b0) begin tests_failed++; $display("FAIL dly_single got %b want 0", id_valid); end
  endtask

  task automatic test_hold();
    drive(); clear_bus(); pc_ce = 1'b1; pc = 32'hBFC0_0008;
    sample();
    drive(); clear_bus(); inst_addr_ok = 1'b1;
    sample();
    drive(); clear_bus(); stall = 6'b000010; inst_data_ok = 1'b1; inst_rdata = 32'h8C02_0004;
    sample();
    tests_run++; if (stallreq_if !== 1'b1) begin tests_failed++; $display("FAIL hold_latch_stallreq got %b want 1", stallreq_if); end
    for (int i = 0; i < 2; i++) begin
      drive(); clear_bus(); stall = 6'b000110; inst_rdata = 32'h0;
      sample();
      tests_run++; if ({id_valid, id_pc, id_inst} !== {1'b0, 32'hBFC0_0004, NOP}) begin
        tests_failed++; $display("FAIL hold_ifid c%0d got %b/%h/%h want 0/bfc00004/%h", i, id_valid, id_pc, id_inst, NOP); end
      tests_run++; if (stallreq_if !== 1'b1) begin tests_failed++; $display("FAIL hold_stallreq c%0d got %b want 1", i, stallreq_if); end
    end
    drive(); clear_bus(); pc_ce = 1'b0;
    sample();
    tests_run++; if (stallreq_if !== 1'b0) begin tests_failed++; $display("FAIL hold_release_stallreq got %b want 0", stallreq_if); end
    drive(); clear_bus();
    sample();
    tests_run++; if ({id_valid, id_pc, id_inst} !== {1'b1, 32'hBFC0_0008, 32'h8C02_0004}) begin
      tests_failed++; $display("FAIL hold_deliver got %b/%h/%h want 1/bfc00008/8c020004", id_valid, id_pc, id_inst); end
    $display("[TB] hold: pc=%h inst=%h valid=%b", id_pc, id_inst, id_valid);
    drive();
    sample();
    tests_run++; if (id_valid !== 1'b0) begin tests_failed++; $display("FAIL hold_once got %b want 0", id_valid); end
  endtask

  task automatic test_flush_wait();
    drive(); clear_bus(); pc_ce = 1'b1; pc = 32'hBFC0_000C;
    sample();
    drive(); clear_bus(); inst_addr_ok = 1'b1;
    sample();
    drive(); clear_bus(); flush = 1'b1; pc = 32'hBFC0_0380;
    sample();
    tests_run++; if (stallreq_if !== 1'b0) begin tests_failed++; $display("FAIL fw_flush_stallreq got %b want 0", stallreq_if); end
    drive(); clear_bus();
    sample();
    tests_run++; if (stallreq_if !== 1'b1) begin tests_failed++; $display("FAIL fw_drop_stallreq got %b want 1", stallreq_if); end
    tests_run++; if ({id_valid, id_inst} !== {1'b0, NOP}) begin tests_failed++; $display("FAIL fw_cleared got %b/%h want 0/%h", id_valid, id_inst, NOP); end
    drive(); clear_bus(); inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
    sample();
    tests_run++; if (stallreq_if !== 1'b1) begin tests_failed++; $display("FAIL fw_drop_data_stallreq got %b want 1", stallreq_if); end
    drive(); clear_bus(); inst_rdata = 32'h0;
    sample();
    tests_run++; if ({id_valid, id_inst} !== {1'b0, NOP}) begin tests_failed++; $display("FAIL fw_no_deadbeef got %b/%h want 0/%h", id_valid, id_inst, NOP); end
    drive(); clear_bus(); inst_addr_ok = 1'b1;
    sample();
    tests_run++; if ({inst_req, inst_addr} !== {1'b1, 32'hBFC0_0380}) begin tests_failed++; $display("FAIL fw_redirect got %b/%h want 1/bfc00380", inst_req, inst_addr); end
    drive(); clear_bus(); inst_data_ok = 1'b1; inst_rdata = 32'h3C1D_A000;
    sample();
    drive(); clear_bus(); pc_ce = 1'b0;
    sample();
    tests_run++; if ({id_valid, id_pc, id_inst} !== {1'b1, 32'hBFC0_0380, 32'h3C1D_A000}) begin
      tests_failed++; $display("FAIL fw_deliver got %b/%h/%h want 1/bfc00380/3c1da000", id_valid, id_pc, id_inst); end
    $display("[TB] flush_wait: pc=%h inst=%h valid=%b", id_pc, id_inst, id_valid);
  endtask

  task automatic test_flush_req();
    drive(); clear_bus(); pc_ce = 1'b1; pc = 32'hBFC0_0010;
    sample();
    drive(); clear_bus(); flush = 1'b1; pc_ce = 1'b0;
    sample();
    tests_run++; if ({inst_req, stallreq_if} !== 2'b10) begin tests_failed++; $display("FAIL fr_flush got req/stall %b%b want 10", inst_req, stallreq_if); end
    for (int i = 0; i < 2; i++) begin
      drive(); clear_bus();
      sample();
      tests_run++; if ({inst_req, stallreq_if} !== 2'b00) begin tests_failed++; $display("FAIL fr_withdrawn c%0d got %b%b want 00", i, inst_req, stallreq_if); end
    end
    drive(); clear_bus(); pc_ce = 1'b1; pc = 32'hBFC0_0014;
    sample();
    drive(); clear_bus(); inst_addr_ok = 1'b1; flush = 1'b1; pc_ce = 1'b0;
    sample();
    tests_run++; if (stallreq_if !== 1'b0) begin tests_failed++; $display("FAIL fr_same_stallreq got %b want 0", stallreq_if); end
    drive(); clear_bus();
    sample();
    tests_run++; if ({inst_req, stallreq_if} !== 2'b01) begin tests_failed++; $display("FAIL fr_drop got %b%b want 01", inst_req, stallreq_if); end
    drive(); clear_bus(); inst_data_ok = 1'b1; inst_rdata = 32'hCAFE_F00D;
    sample();
    tests_run++; if (stallreq_if !== 1'b1) begin tests_failed++; $display("FAIL fr_drop_data got %b want 1", stallreq_if); end
    drive(); clear_bus(); inst_rdata = 32'h0;
    sample();
    tests_run++; if ({id_valid, id_inst, stallreq_if} !== {1'b0, NOP, 1'b0}) begin
      tests_failed++; $display("FAIL fr_consumed got %b/%h/%b want 0/%h/0", id_valid, id_inst, stallreq_if, NOP); end
  endtask

  task automatic test_reset_mid();
    drive(); clear_bus(); pc_ce = 1'b1; pc = 32'hBFC0_0018;
    sample();
    drive(); clear_bus(); inst_addr_ok = 1'b1;
    sample();
    drive(); clear_bus();
    #2;
    rstn = 1'b0; pc_ce = 1'b0;
    #1;
    tests_run++; if ({inst_req, inst_addr, stallreq_if} !== {1'b0, 32'h0, 1'b0}) begin
      tests_failed++; $display("FAIL rm_bus got %b/%h/%b want 0/0/0", inst_req, inst_addr, stallreq_if); end
    tests_run++; if ({id_valid, id_pc, id_inst} !== {1'b0, 32'h0, NOP}) begin
      tests_failed++; $display("FAIL rm_ifid got %b/%h/%h want 0/0/%h", id_valid, id_pc, id_inst, NOP); end
    drive(); rstn = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'hBAD0_BAD0;
    sample();
    tests_run++; if ({inst_req, stallreq_if, id_valid} !== 3'b000) begin tests_failed++; $display("FAIL rm_stray got %b%b%b want 000", inst_req, stallreq_if, id_valid); end
    drive(); clear_bus(); inst_rdata = 32'h0;
    sample();
    tests_run++; if ({id_valid, id_pc, id_inst} !== {1'b0, 32'h0, NOP}) begin
      tests_failed++; $display("FAIL rm_after got %b/%h/%h want 0/0/%h", id_valid, id_pc, id_inst, NOP); end
  endtask

  // Reference model: tracks the single transaction as a set of flags (presenting,
  // outstanding-for-delivery, outstanding-to-discard, buffered) plus the IF/ID contents.
  task automatic test_random(input int n_cycles);
    bit          m_req, m_out, m_drop, m_hold, bus_pending;
    logic [31:0] m_addr, m_buf, m_id_pc, m_id_inst;
    bit          m_id_valid;
    bit          idle, dlv, exp_stallreq;
    logic [31:0] word;
    bit          n_req, n_out, n_drop, n_hold;
    int          delivered;
    m_req = 0; m_out = 0; m_drop = 0; m_hold = 0; bus_pending = 0;
    m_addr = 32'h0; m_buf = 32'h0; m_id_pc = 32'h0; m_id_inst = NOP; m_id_valid = 0;
    delivered = 0;
    for (int cyc = 0; cyc < n_cycles; cyc++) begin
      drive();
      pc_ce        = ($urandom_range(0, 3) != 0);
      pc           = $urandom() & 32'hFFFF_FFFC;
      stall        = 6'($urandom()) & 6'b111101;
      if ($urandom_range(0, 3) == 0) stall[1] = 1'b1;
      flush        = ($urandom_range(0, 9) == 0);
      inst_addr_ok = m_req && ($urandom_range(0, 1) == 0);
      inst_data_ok = bus_pending && ($urandom_range(0, 2) == 0);
      inst_rdata   = $urandom();
      sample();

      idle = !m_req && !m_out && !m_drop && !m_hold;
      dlv  = !flush && !stall[1] && ((m_out && inst_data_ok) || m_hold);
      word = m_hold ? m_buf : inst_rdata;
      if (m_drop) exp_stallreq = 1;
      else if (flush || dlv) exp_stallreq = 0;
      else if (idle) exp_stallreq = pc_ce;
      else exp_stallreq = 1;

      tests_run++; if (inst_req !== m_req) begin tests_failed++; $display("FAIL rnd_req cyc=%0d got %b want %b", cyc, inst_req, m_req); end
      tests_run++; if (inst_addr !== m_addr) begin tests_failed++; $display("FAIL rnd_addr cyc=%0d got %h want %h", cyc, inst_addr, m_addr); end
      tests_run++; if (stallreq_if !== exp_stallreq) begin tests_failed++; $display("FAIL rnd_stallreq cyc=%0d got %b want %b", cyc, stallreq_if, exp_stallreq); end
      tests_run++; if ({id_valid, id_pc, id_inst} !== {m_id_valid, m_id_pc, m_id_inst}) begin
        tests_failed++; $display("FAIL rnd_ifid cyc=%0d got %b/%h/%h want %b/%h/%h", cyc, id_valid, id_pc, id_inst, m_id_valid, m_id_pc, m_id_inst); end

      if (flush) begin
        m_id_valid = 0; m_id_inst = NOP;
      end else if (!stall[1]) begin
        if (dlv) begin
          m_id_valid = 1; m_id_pc = m_addr; m_id_inst = word;
          delivered++;
          $display("[TB] random: deliver #%0d pc=%h inst=%h", delivered, m_addr, word);
        end else begin
          m_id_valid = 0; m_id_inst = NOP;
        end
      end

      n_req = m_req; n_out = m_out; n_drop = m_drop; n_hold = m_hold;
      if (idle && pc_ce && !flush) begin n_req = 1; m_addr = pc; end
      if (m_req) begin
        if (inst_addr_ok) begin n_req = 0; if (flush) n_drop = 1; else n_out = 1; end
        else if (flush) n_req = 0;
      end
      if (m_out) begin
        if (inst_data_ok) begin
          n_out = 0;
          if (!flush && stall[1]) begin n_hold = 1; m_buf = inst_rdata; end
        end else if (flush) begin
          n_out = 0; n_drop = 1;
        end
      end
      if (m_hold && (flush || !stall[1])) n_hold = 0;
      if (m_drop && inst_data_ok) n_drop = 0;
      if (inst_data_ok) bus_pending = 0;
      if (m_req && inst_addr_ok) bus_pending = 1;
      m_req = n_req; m_out = n_out; m_drop = n_drop; m_hold = n_hold;
    end
    drive(); clear_bus(); pc_ce = 1'b0;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_zero_wait();
    test_addr_delay();
    test_hold();
    test_flush_wait();
    test_flush_req();
    test_reset_mid();
    test_random(1500);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
